// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and the nibble-to-glyph function for the
// seven-segment scan driver.
//   SEG_BLANK   : all segments (and DP) dark, active-low encoding.
//   GLYPH_*     : seg[6:0] = {G,F,E,D,C,B,A}, active-low.
//   seg7_glyph  : nibble + hex_mode -> 7-bit glyph; BCD mode blanks 10..15.
package seg7_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [6:0] GLYPH_0   = 7'b100_0000;
  localparam logic [6:0] GLYPH_1   = 7'b111_1001;
  localparam logic [6:0] GLYPH_2   = 7'b010_0100;
  localparam logic [6:0] GLYPH_3   = 7'b011_0000;
  localparam logic [6:0] GLYPH_4   = 7'b001_1001;
  localparam logic [6:0] GLYPH_5   = 7'b001_0010;
  localparam logic [6:0] GLYPH_6   = 7'b000_0010;
  localparam logic [6:0] GLYPH_7   = 7'b111_1000;
  localparam logic [6:0] GLYPH_8   = 7'b000_0000;
  localparam logic [6:0] GLYPH_9   = 7'b001_0000;
  localparam logic [6:0] GLYPH_A   = 7'b000_1000;
  localparam logic [6:0] GLYPH_B   = 7'b000_0011;
  localparam logic [6:0] GLYPH_C   = 7'b100_0110;
  localparam logic [6:0] GLYPH_D   = 7'b010_0001;
  localparam logic [6:0] GLYPH_E   = 7'b000_0110;
  localparam logic [6:0] GLYPH_F   = 7'b000_1110;
  localparam logic [6:0] GLYPH_OFF = 7'b111_1111;

  function automatic logic [6:0] seg7_glyph(input logic [3:0] nibble, input logic hex_mode);
    logic [6:0] g;
    case (nibble)
      4'h0:    g = GLYPH_0;
      4'h1:    g = GLYPH_1;
      4'h2:    g = GLYPH_2;
      4'h3:    g = GLYPH_3;
      4'h4:    g = GLYPH_4;
      4'h5:    g = GLYPH_5;
      4'h6:    g = GLYPH_6;
      4'h7:    g = GLYPH_7;
      4'h8:    g = GLYPH_8;
      4'h9:    g = GLYPH_9;
      4'hA:    g = GLYPH_A;
      4'hB:    g = GLYPH_B;
      4'hC:    g = GLYPH_C;
      4'hD:    g = GLYPH_D;
      4'hE:    g = GLYPH_E;
      default: g = GLYPH_F;
    endcase
    // Non-decimal nibbles are dark unless hex glyphs are enabled.
    if (!hex_mode && (nibble > 4'd9)) g = GLYPH_OFF;
    return g;
  endfunction

endpackage

// File: rtl/seg7_glyph_rom.sv
// seg7_glyph_rom: combinational nibble-to-glyph lookup.
//   HEX_MODE : 0 = BCD (10..15 dark), 1 = hex glyphs A..F.
//   nibble   : 4-bit digit value.
//   glyph    : seg[6:0] pattern, active-low.
module seg7_glyph_rom
  import seg7_pkg::*;
#(
  parameter bit HEX_MODE = 1'b0
) (
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = seg7_glyph(nibble, HEX_MODE);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for an N-digit common-anode
// seven-segment display with per-digit DP, blanking and blink.
//   clk, rst   : clock; synchronous active-high reset.
//   digits     : nibble i = digits[4i+3:4i]; digit 0 is rightmost.
//   dp_in      : per-digit decimal point, 1 = lit.
//   blank_mask : per-digit force dark.
//   blink_mask : per-digit blink, gated by blink_en.
//   seg        : {DP,G,F,E,D,C,B,A}, active-low, registered.
//   an         : anode enables, active-low, at most one low, registered.
//   scan_idx   : digit currently being scanned.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 25000000,
  parameter bit          HEX_MODE    = 1'b0
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic [4*NUM_DIGITS-1:0]                             digits,
  input  logic [NUM_DIGITS-1:0]                               dp_in,
  input  logic [NUM_DIGITS-1:0]                               blank_mask,
  input  logic [NUM_DIGITS-1:0]                               blink_mask,
  input  logic                                                blink_en,
  output logic [7:0]                                          seg,
  output logic [NUM_DIGITS-1:0]                               an,
  output logic [(NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1)-1:0] scan_idx
);

  localparam int unsigned SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned RW = $clog2(REFRESH_DIV);
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [SW-1:0] SCAN_LAST    = SW'(NUM_DIGITS - 1);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

  logic [RW-1:0]         refresh_cnt_q, refresh_cnt_d;
  logic [BW-1:0]         blink_cnt_q, blink_cnt_d;
  logic                  blink_phase_q, blink_phase_d;
  logic [SW-1:0]         scan_idx_q, scan_idx_d;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic [3:0]            cur_nibble;
  logic [6:0]            cur_glyph;
  logic [NUM_DIGITS-1:0] cur_sel;

  assign cur_nibble = digits[{scan_idx_q, 2'b00} +: 4];
  assign cur_sel    = NUM_DIGITS'(1) << scan_idx_q;

  seg7_glyph_rom #(
    .HEX_MODE (HEX_MODE)
  ) u_glyph_rom (
    .nibble (cur_nibble),
    .glyph  (cur_glyph)
  );

  // Counters: scan advances on the last cycle of a slot so that every new
  // slot begins with refresh_cnt == 0, which is the anode dead-time cycle.
  always_comb begin
    refresh_cnt_d = refresh_cnt_q + 1'b1;
    scan_idx_d    = scan_idx_q;
    if (refresh_cnt_q == REFRESH_LAST) begin
      refresh_cnt_d = '0;
      scan_idx_d    = (scan_idx_q == SCAN_LAST) ? '0 : scan_idx_q + 1'b1;
    end

    blink_cnt_d   = blink_cnt_q + 1'b1;
    blink_phase_d = blink_phase_q;
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end
  end

  // Output priority: dead-time, blank, blink-off, normal glyph.
  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = '1;
    if ((refresh_cnt_q == '0) || blank_mask[scan_idx_q]) begin
      seg_d = SEG_BLANK;
      an_d  = '1;
    end else if (blink_en && blink_phase_q && blink_mask[scan_idx_q]) begin
      an_d = ~cur_sel;
    end else begin
      an_d  = ~cur_sel;
      seg_d = {~dp_in[scan_idx_q], cur_glyph};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt_q <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      scan_idx_q    <= '0;
      seg_q         <= SEG_BLANK;
      an_q          <= '1;
    end else begin
      refresh_cnt_q <= refresh_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      scan_idx_q    <= scan_idx_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
    end
  end

  assign seg      = seg_q;
  assign an       = an_q;
  assign scan_idx = scan_idx_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a BCD and a hex instance share all
// inputs; stimulus pushes the expected registered outputs for every edge and
// a monitor pops and compares one entry per clock.
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int BD = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] digits;
  logic [3:0]  dp_in, blank_mask, blink_mask;
  logic        blink_en;
  logic [7:0]  seg_b, seg_h;
  logic [3:0]  an_b, an_h;
  logic [1:0]  scan_b, scan_h;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NUM_DIGITS (ND), .REFRESH_DIV (RD), .BLINK_DIV (BD), .HEX_MODE (1'b0)
  ) dut_bcd (
    .clk (clk), .rst (rst), .digits (digits), .dp_in (dp_in),
    .blank_mask (blank_mask), .blink_mask (blink_mask), .blink_en (blink_en),
    .seg (seg_b), .an (an_b), .scan_idx (scan_b)
  );

  seg7_scan_driver #(
    .NUM_DIGITS (ND), .REFRESH_DIV (RD), .BLINK_DIV (BD), .HEX_MODE (1'b1)
  ) dut_hex (
    .clk (clk), .rst (rst), .digits (digits), .dp_in (dp_in),
    .blank_mask (blank_mask), .blink_mask (blink_mask), .blink_en (blink_en),
    .seg (seg_h), .an (an_h), .scan_idx (scan_h)
  );

  // Hand-written glyph tables, seg[6:0] active-low.
  logic [6:0] tab_bcd [16] = '{
    7'b100_0000, 7'b111_1001, 7'b010_0100, 7'b011_0000,
    7'b001_1001, 7'b001_0010, 7'b000_0010, 7'b111_1000,
    7'b000_0000, 7'b001_0000, 7'b111_1111, 7'b111_1111,
    7'b111_1111, 7'b111_1111, 7'b111_1111, 7'b111_1111};
  logic [6:0] tab_hex [16] = '{
    7'b100_0000, 7'b111_1001, 7'b010_0100, 7'b011_0000,
    7'b001_1001, 7'b001_0010, 7'b000_0010, 7'b111_1000,
    7'b000_0000, 7'b001_0000, 7'b000_1000, 7'b000_0011,
    7'b100_0110, 7'b010_0001, 7'b000_0110, 7'b000_1110};

  typedef struct {
    string      name;
    logic [3:0] an;
    logic [7:0] seg_b;
    logic [7:0] seg_h;
    logic [1:0] scan;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference state as seen just after the most recent pushed edge.
  int m_ref = 0, m_blk = 0, m_ph = 0, m_scan = 0;

  function automatic void chk(string what, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", what, act, exp, $time);
    end
  endfunction

  // Push the expectation for the coming posedge, then advance to the negedge.
  task automatic step(string name);
    exp_t       e;
    logic [3:0] nib;
    e.name = name;
    if (rst) begin
      e.an = 4'hF; e.seg_b = 8'hFF; e.seg_h = 8'hFF;
      m_ref = 0; m_blk = 0; m_ph = 0; m_scan = 0;
    end else begin
      nib = digits[4*m_scan +: 4];
      e.an = 4'hF; e.seg_b = 8'hFF; e.seg_h = 8'hFF;
      if (m_ref == 0 || blank_mask[m_scan]) begin
        e.an = 4'hF;
      end else if (blink_en && m_ph == 1 && blink_mask[m_scan]) begin
        e.an = ~(4'b0001 << m_scan);
      end else begin
        e.an    = ~(4'b0001 << m_scan);
        e.seg_b = {~dp_in[m_scan], tab_bcd[nib]};
        e.seg_h = {~dp_in[m_scan], tab_hex[nib]};
      end
      if (m_ref == RD - 1) begin
        m_ref  = 0;
        m_scan = (m_scan == ND - 1) ? 0 : m_scan + 1;
      end else begin
        m_ref++;
      end
      if (m_blk == BD - 1) begin
        m_blk = 0;
        m_ph  = 1 - m_ph;
      end else begin
        m_blk++;
      end
    end
    e.scan = 2'(m_scan);
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic run(int n, string name);
    repeat (n) step(name);
  endtask

  // Monitor: outputs are presented every cycle; sample 1 time unit after the edge.
  exp_t cur;
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      chk({cur.name, "/an_bcd"},   {4'h0, an_b},   {4'h0, cur.an});
      chk({cur.name, "/an_hex"},   {4'h0, an_h},   {4'h0, cur.an});
      chk({cur.name, "/seg_bcd"},  seg_b,          cur.seg_b);
      chk({cur.name, "/seg_hex"},  seg_h,          cur.seg_h);
      chk({cur.name, "/scan_bcd"}, {6'h0, scan_b}, {6'h0, cur.scan});
      chk({cur.name, "/scan_hex"}, {6'h0, scan_h}, {6'h0, cur.scan});
      checks++;
      if ($countones(~an_b) > 1 || $countones(~an_h) > 1) begin
        errors++;
        $display("FAIL %s/an_onehot: got %b %b expected at most one low", cur.name, an_b, an_h);
      end
    end
  end

  initial begin
    int guard;
    rst = 1'b1; digits = 16'h4321; dp_in = '0; blank_mask = '0; blink_mask = '0;
    blink_en = 1'b0;
    run(3, "reset");

    rst = 1'b0;
    run(40, "scan_order");

    digits = 16'h000A;
    run(16, "nibble_a");
    dp_in = 4'b0001;
    run(16, "nibble_a_dp");

    dp_in = '0; digits = 16'h0808; blink_mask = 4'b0101; blink_en = 1'b1;
    run(48, "blink_on");
    blink_en = 1'b0;
    run(16, "blink_off");

    digits = 16'h4321; blank_mask = 4'b0010; blink_mask = 4'b0010; dp_in = 4'b0010;
    blink_en = 1'b1;
    run(32, "blank_prio");

    blank_mask = '0; blink_mask = '0; dp_in = '0; blink_en = 1'b0;
    guard = 0;
    while (m_scan != 2 && guard < 64) begin
      step("pre_midreset");
      guard++;
    end
    checks++;
    if (m_scan != 2) begin
      errors++;
      $display("FAIL midreset_reach: got scan %0d expected 2", m_scan);
    end
    step("pre_midreset");
    rst = 1'b1;
    run(1, "midreset");
    rst = 1'b0;
    run(20, "post_midreset");

    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
